// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one-outstanding fetches and buffers one instruction.
// Optional statistics counters are enabled with `define FETCH_STATS_EN.
module fetch_sequencer #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic             imem_req_o,
    output logic [PC_W-1:0]  imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [31:0]      imem_rdata_i,
    output logic             if_valid_o,
    output logic [31:0]      if_instr_o,
    output logic [PC_W-1:0]  if_pc_o,
    input  logic             if_ready_i,
    output logic             flush_o,
    output logic [CNT_W-1:0] stat_taken_o,
    output logic [CNT_W-1:0] stat_kill_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic            req, redir, fill, kill, pop;
    logic            unused;

    assign unused      = ^{redirect_pc_i[31:PC_W], redirect_pc_i[1:0]};
    assign redir       = redirect_i && (state != IDLE);
    assign pop         = if_valid_o && if_ready_i;
    assign imem_req_o  = req;
    assign imem_addr_o = pc;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        req     = 1'b0;
        fill    = 1'b0;
        kill    = 1'b0;
        unique case (state)
            IDLE: state_n = REQ;
            REQ: begin
                req = !if_valid_o || if_ready_i;
                if (req && imem_gnt_i) begin
                    pc_n    = pc + PC_W'(4);
                    state_n = redir ? DISCARD : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    kill    = redir;
                    fill    = !redir;
                    state_n = REQ;
                end else if (redir) begin
                    state_n = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_rvalid_i) begin
                    kill    = 1'b1;
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
        if (redir) pc_n = {redirect_pc_i[PC_W-1:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            if_valid_o <= 1'b0;
            if_instr_o <= '0;
            if_pc_o    <= '0;
            flush_o    <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            flush_o <= redir;
            if (redir) begin
                if_valid_o <= 1'b0;
            end else if (fill) begin
                // pc already advanced at grant, so the fetched PC is one word back
                if_valid_o <= 1'b1;
                if_instr_o <= imem_rdata_i;
                if_pc_o    <= pc - PC_W'(4);
            end else if (pop) begin
                if_valid_o <= 1'b0;
            end
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_taken_o <= '0;
            stat_kill_o  <= '0;
        end else begin
            if (redir && stat_taken_o != '1) stat_taken_o <= stat_taken_o + 1'b1;
            if (kill && stat_kill_o != '1)   stat_kill_o  <= stat_kill_o + 1'b1;
        end
    end
`else
    assign stat_taken_o = '0;
    assign stat_kill_o  = '0;
`endif

endmodule
